// File: rtl/hazard_ctrl_param.sv
// Hazard and stall controller for the 5-stage rv32i pipeline: load scoreboard,
// redirect/flush FSM and saturating performance counters.
module hazard_ctrl_param #(
   parameter int REG_IDX_W    = 5,
   parameter int LOAD_USE_LAT = 1,
   parameter int FLUSH_DEPTH  = 1,
   parameter int CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_mem_resp,
   input  logic                 data_mem_resp,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_valid,
   input  logic                 ex_is_load,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_mispredict,
   input  logic                 mem_valid,
   input  logic                 mem_is_mem,
   output logic                 load_buffers,
   output logic                 load_pc,
   output logic                 idex_bubble,
   output logic                 ifid_kill,
   output logic                 pc_correct,
   output logic [1:0]           busy_state,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, MEM_STALL = 2'd1, FLUSH = 2'd2} state_t;

   localparam int SB_N = LOAD_USE_LAT - 1;
   localparam int SB_W = (SB_N > 0) ? SB_N : 1;
   localparam int FC_W = 3;
   localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(FLUSH_DEPTH - 1);

   state_t              state_q, state_d;
   logic [FC_W-1:0]     fcnt_q, fcnt_d;
   logic                mem_ok, redirect, hazard, rs1_hit, rs2_hit;
   logic                accept_redirect, accept_bubble;
   logic [SB_W-1:0]     sb_v;
   logic [REG_IDX_W-1:0] sb_rd [SB_W];

   // Handshake: load_buffers is the one "ready" shared by every pipeline buffer;
   // a buffer advances only in a cycle where it is 1, and every other control
   // except pc_correct is qualified by it, so nothing moves during a stall.
   always_comb begin
      mem_ok          = !(mem_valid && mem_is_mem) || data_mem_resp;
      load_buffers    = rst && inst_mem_resp && mem_ok;
      redirect        = ex_valid && ex_mispredict;
      accept_redirect = load_buffers && redirect;
   end

   always_comb begin
      rs1_hit = ex_valid && ex_is_load && (ex_rd == id_rs1);
      rs2_hit = ex_valid && ex_is_load && (ex_rd == id_rs2);
      for (int i = 0; i < SB_N; i++) begin
         if (sb_v[i] && (sb_rd[i] == id_rs1)) rs1_hit = 1'b1;
         if (sb_v[i] && (sb_rd[i] == id_rs2)) rs2_hit = 1'b1;
      end
      hazard = id_valid && ((id_use_rs1 && (id_rs1 != '0) && rs1_hit) ||
                            (id_use_rs2 && (id_rs2 != '0) && rs2_hit));
      accept_bubble = load_buffers && !redirect && hazard;
   end

   // Slot k holds a load that left EX k+1 advances ago; squashed loads never enter.
   generate
      if (SB_N > 0) begin : g_sb
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sb_v <= '0;
               for (int i = 0; i < SB_N; i++) sb_rd[i] <= '0;
            end else if (load_buffers) begin
               sb_v[0]  <= ex_valid && ex_is_load && (ex_rd != '0) && !redirect;
               sb_rd[0] <= ex_rd;
               for (int i = 1; i < SB_N; i++) begin
                  sb_v[i]  <= sb_v[i-1];
                  sb_rd[i] <= sb_rd[i-1];
               end
            end
         end
      end else begin : g_no_sb
         assign sb_v     = '0;
         assign sb_rd[0] = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // The redirect cycle is the first kill; FLUSH covers the remaining FLUSH_DEPTH-1.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (accept_redirect) begin
         if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
         end else begin
            state_d = RUN;
            fcnt_d  = '0;
         end
      end else begin
         case (state_q)
            RUN:       if (!load_buffers) state_d = MEM_STALL;
            MEM_STALL: if (load_buffers)  state_d = RUN;
            FLUSH: begin
               if (load_buffers) begin
                  if (fcnt_q <= FC_W'(1)) begin
                     state_d = RUN;
                     fcnt_d  = '0;
                  end else begin
                     fcnt_d  = fcnt_q - 1'b1;
                  end
               end
            end
            default:   state_d = RUN;
         endcase
      end
   end

   always_comb begin
      pc_correct  = rst && redirect;
      load_pc     = load_buffers && (redirect || !hazard);
      idex_bubble = load_buffers && (redirect || hazard);
      ifid_kill   = load_buffers && (redirect || (state_q == FLUSH));
      busy_state  = state_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (!load_buffers && (stall_cnt != {CNT_W{1'b1}}))   stall_cnt  <= stall_cnt + 1'b1;
         if (accept_bubble && (bubble_cnt != {CNT_W{1'b1}}))  bubble_cnt <= bubble_cnt + 1'b1;
         if (accept_redirect && (flush_cnt != {CNT_W{1'b1}})) flush_cnt  <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: a default instance and a LAT=3/DEPTH=3/4-bit
// counter instance share one stimulus stream.
module tb_hazard_ctrl_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic inst_mem_resp, data_mem_resp, id_valid, id_use_rs1, id_use_rs2;
   logic ex_valid, ex_is_load, ex_mispredict, mem_valid, mem_is_mem;
   logic [4:0] id_rs1, id_rs2, ex_rd;

   logic [1:0]  o_lb, o_lpc, o_bub, o_kill, o_pcc;
   logic [1:0]  st0, st1;
   logic [31:0] s0, b0, f0;
   logic [3:0]  s1, b1, f1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl_param u0 (
      .clk(clk), .rst(rst), .inst_mem_resp(inst_mem_resp), .data_mem_resp(data_mem_resp),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_mispredict(ex_mispredict), .mem_valid(mem_valid), .mem_is_mem(mem_is_mem),
      .load_buffers(o_lb[0]), .load_pc(o_lpc[0]), .idex_bubble(o_bub[0]), .ifid_kill(o_kill[0]),
      .pc_correct(o_pcc[0]), .busy_state(st0), .stall_cnt(s0), .bubble_cnt(b0), .flush_cnt(f0));

   hazard_ctrl_param #(.LOAD_USE_LAT(3), .FLUSH_DEPTH(3), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .inst_mem_resp(inst_mem_resp), .data_mem_resp(data_mem_resp),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_mispredict(ex_mispredict), .mem_valid(mem_valid), .mem_is_mem(mem_is_mem),
      .load_buffers(o_lb[1]), .load_pc(o_lpc[1]), .idex_bubble(o_bub[1]), .ifid_kill(o_kill[1]),
      .pc_correct(o_pcc[1]), .busy_state(st1), .stall_cnt(s1), .bubble_cnt(b1), .flush_cnt(f1));

   // Reference model: per instance, the advance index at which each register was
   // last written by a recorded load, and how many IF/ID kills remain after a redirect.
   int     lat [2] = '{1, 3};
   int     fd  [2] = '{1, 3};
   longint cmax[2] = '{64'hffff_ffff, 15};
   longint adv_n[2];
   longint last_rec[2][32];
   int     kills_left[2];
   bit     prev_stall[2];
   longint m_stall[2], m_bub[2], m_flush[2];
   bit     haz[2];
   bit     redir, e_lb;
   logic [1:0] e_lpc, e_bub, e_kill;
   int     e_st[2];

   function automatic bit reg_busy(int c, logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
      if (ex_valid && ex_is_load && ex_rd == rs) return 1'b1;
      return (adv_n[c] - last_rec[c][rs]) <= longint'(lat[c] - 1);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         adv_n[c] = 0; kills_left[c] = 0; prev_stall[c] = 1'b0;
         m_stall[c] = 0; m_bub[c] = 0; m_flush[c] = 0;
         for (int r = 0; r < 32; r++) last_rec[c][r] = -100;
      end
   endtask

   task automatic model_eval();
      redir = ex_valid && ex_mispredict;
      e_lb  = inst_mem_resp && (!(mem_valid && mem_is_mem) || data_mem_resp);
      for (int c = 0; c < 2; c++) begin
         haz[c] = id_valid && ((id_use_rs1 && reg_busy(c, id_rs1)) || (id_use_rs2 && reg_busy(c, id_rs2)));
         e_lpc[c]  = e_lb && (redir || !haz[c]);
         e_bub[c]  = e_lb && (redir || haz[c]);
         e_kill[c] = e_lb && (redir || kills_left[c] > 0);
         e_st[c]   = (kills_left[c] > 0) ? 2 : (prev_stall[c] ? 1 : 0);
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < 2; c++) begin
         if (e_lb) begin
            if (ex_valid && ex_is_load && ex_rd != 5'd0 && !redir) last_rec[c][ex_rd] = adv_n[c];
            adv_n[c]++;
            if (redir) begin
               kills_left[c] = fd[c] - 1;
               if (m_flush[c] < cmax[c]) m_flush[c]++;
            end else begin
               if (kills_left[c] > 0) kills_left[c]--;
               if (haz[c] && m_bub[c] < cmax[c]) m_bub[c]++;
            end
         end else if (m_stall[c] < cmax[c]) begin
            m_stall[c]++;
         end
         prev_stall[c] = !e_lb;
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_mispredict = 0;
      mem_valid = 0; mem_is_mem = 0; inst_mem_resp = 1; data_mem_resp = 1;
   endtask

   task automatic settle(); @(negedge clk); endtask
   task automatic tick();   @(posedge clk); #1; endtask

   task automatic do_reset();
      rst = 0; idle();
      @(negedge clk); @(posedge clk); #1;
      rst = 1;
   endtask

   task automatic test_reset();
      inst_mem_resp = 1; data_mem_resp = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
      ex_mispredict = 1; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
      settle();
      n_vec++; if (o_lb   !== 2'b00) begin n_err++; $display("FAIL reset_lb: got %b want 00", o_lb); end
      n_vec++; if (o_lpc  !== 2'b00) begin n_err++; $display("FAIL reset_lpc: got %b want 00", o_lpc); end
      n_vec++; if (o_bub  !== 2'b00) begin n_err++; $display("FAIL reset_bub: got %b want 00", o_bub); end
      n_vec++; if (o_kill !== 2'b00) begin n_err++; $display("FAIL reset_kill: got %b want 00", o_kill); end
      n_vec++; if (o_pcc  !== 2'b00) begin n_err++; $display("FAIL reset_pcc: got %b want 00", o_pcc); end
      n_vec++; if ({st1, st0} !== 4'b0) begin n_err++; $display("FAIL reset_state: got %b want 0000", {st1, st0}); end
      n_vec++; if ({s0, b0, f0, s1, b1, f1} !== 108'b0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", {s0, b0, f0, s1, b1, f1}); end
      @(posedge clk); #1; rst = 1; idle();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
      settle();
      n_vec++; if (o_bub[0] !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %b want 1", o_bub[0]); end
      n_vec++; if (o_lpc[0] !== 1'b0) begin n_err++; $display("FAIL lu_hold_pc: got %b want 0", o_lpc[0]); end
      tick(); ex_valid = 0; ex_is_load = 0;
      settle();
      n_vec++; if (o_lpc[0] !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", o_lpc[0]); end
      n_vec++; if (o_bub[0] !== 1'b0) begin n_err++; $display("FAIL lu_no_bubble: got %b want 0", o_bub[0]); end
      tick(); idle(); settle();
      n_vec++; if (b0 !== 32'd1) begin n_err++; $display("FAIL lu_bubble_cnt: got %0d want 1", b0); end
   endtask

   task automatic test_lat3();
      bit want_bub[4] = '{0, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ex_valid = (i == 0); ex_is_load = (i == 0); ex_rd = 7;
         id_valid = 1; id_use_rs1 = 1; id_rs1 = (i == 0) ? 5'd3 : 5'd7;
         settle();
         n_vec++; if (o_bub !== {want_bub[i], 1'b0}) begin n_err++; $display("FAIL lat3_bub%0d: got %b want %b0", i, o_bub, want_bub[i]); end
         tick();
      end
      ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
      settle();
      n_vec++; if (o_bub !== 2'b00) begin n_err++; $display("FAIL lat3_x0_ex: got %b want 00", o_bub); end
      tick(); ex_valid = 0; ex_is_load = 0;
      settle();
      n_vec++; if (o_bub !== 2'b00) begin n_err++; $display("FAIL lat3_x0_sb: got %b want 00", o_bub); end
      tick(); idle(); settle();
      n_vec++; if (b1 !== 4'd2) begin n_err++; $display("FAIL lat3_cnt1: got %0d want 2", b1); end
      n_vec++; if (b0 !== 32'd0) begin n_err++; $display("FAIL lat3_cnt0: got %0d want 0", b0); end
   endtask

   task automatic test_redirect_hazard();
      do_reset();
      ex_valid = 1; ex_is_load = 1; ex_rd = 5; ex_mispredict = 1; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
      settle();
      n_vec++; if (o_pcc  !== 2'b11) begin n_err++; $display("FAIL rh_pcc: got %b want 11", o_pcc); end
      n_vec++; if (o_kill !== 2'b11) begin n_err++; $display("FAIL rh_kill: got %b want 11", o_kill); end
      n_vec++; if (o_lpc  !== 2'b11) begin n_err++; $display("FAIL rh_lpc: got %b want 11", o_lpc); end
      n_vec++; if (o_bub  !== 2'b11) begin n_err++; $display("FAIL rh_bub: got %b want 11", o_bub); end
      tick(); ex_valid = 0; ex_is_load = 0; ex_mispredict = 0;
      settle();
      n_vec++; if (o_bub  !== 2'b00) begin n_err++; $display("FAIL rh_squashed: got %b want 00", o_bub); end
      n_vec++; if (o_kill !== 2'b10) begin n_err++; $display("FAIL rh_flush_kill: got %b want 10", o_kill); end
      n_vec++; if ({st1, st0} !== {2'd2, 2'd0}) begin n_err++; $display("FAIL rh_state: got %b want 1000", {st1, st0}); end
      n_vec++; if (f0 !== 32'd1) begin n_err++; $display("FAIL rh_flush_cnt: got %0d want 1", f0); end
      n_vec++; if (b0 !== 32'd0) begin n_err++; $display("FAIL rh_bubble_cnt: got %0d want 0", b0); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      ex_valid = 1; ex_mispredict = 1; mem_valid = 1; mem_is_mem = 1; data_mem_resp = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
         n_vec++; if (o_lb !== 2'b00) begin n_err++; $display("FAIL ms_lb%0d: got %b want 00", i, o_lb); end
         n_vec++; if (o_pcc !== 2'b11) begin n_err++; $display("FAIL ms_pcc%0d: got %b want 11", i, o_pcc); end
         n_vec++; if ({o_lpc, o_kill} !== 4'b0) begin n_err++; $display("FAIL ms_ctl%0d: got %b want 0000", i, {o_lpc, o_kill}); end
         if (i > 0) begin
            n_vec++; if ({st1, st0} !== 4'b0101) begin n_err++; $display("FAIL ms_state%0d: got %b want 0101", i, {st1, st0}); end
         end
         tick();
      end
      data_mem_resp = 1;
      settle();
      n_vec++; if ({o_lb, o_lpc, o_kill, o_pcc} !== 8'hff) begin n_err++; $display("FAIL ms_accept: got %b want 11111111", {o_lb, o_lpc, o_kill, o_pcc}); end
      tick(); idle(); settle();
      n_vec++; if (s0 !== 32'd4) begin n_err++; $display("FAIL ms_stall_cnt: got %0d want 4", s0); end
      n_vec++; if (f0 !== 32'd1) begin n_err++; $display("FAIL ms_flush_cnt: got %0d want 1", f0); end
      n_vec++; if ({st1, st0} !== {2'd2, 2'd0}) begin n_err++; $display("FAIL ms_after: got %b want 1000", {st1, st0}); end
   endtask

   task automatic test_flush();
      bit pat_resp[10]  = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 1};
      bit pat_redir[10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      int rem = 0;
      bit prev0 = 0;
      bit exp_k;
      int exp_st;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         inst_mem_resp = pat_resp[i]; ex_valid = pat_redir[i]; ex_mispredict = pat_redir[i];
         settle();
         exp_k  = pat_resp[i] && (pat_redir[i] || rem > 0);
         exp_st = (rem > 0) ? 2 : (prev0 ? 1 : 0);
         n_vec++; if (o_kill[1] !== exp_k) begin n_err++; $display("FAIL fl_kill%0d: got %b want %b", i, o_kill[1], exp_k); end
         n_vec++; if (st1 !== 2'(exp_st)) begin n_err++; $display("FAIL fl_state%0d: got %0d want %0d", i, st1, exp_st); end
         if (pat_resp[i]) begin
            if (pat_redir[i]) rem = 2;
            else if (rem > 0) rem--;
         end
         prev0 = !pat_resp[i];
         tick();
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      inst_mem_resp = 0;
      repeat (20) @(posedge clk);
      #1;
      n_vec++; if ({st1, st0} !== 4'b0101) begin n_err++; $display("FAIL sat_state: got %b want 0101", {st1, st0}); end
      inst_mem_resp = 1;
      settle();
      n_vec++; if (s1 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4: got %0d want 15", s1); end
      n_vec++; if (s0 !== 32'd20) begin n_err++; $display("FAIL sat_cnt32: got %0d want 20", s0); end
      tick();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      ex_valid = 1; ex_mispredict = 1;
      tick(); ex_valid = 0; ex_mispredict = 0;
      tick();
      ex_valid = 1; ex_mispredict = 1; ex_is_load = 1; ex_rd = 4; id_valid = 1; id_rs1 = 4; id_use_rs1 = 1;
      #3; rst = 0; #1;
      n_vec++; if ({o_lb, o_lpc, o_bub, o_kill, o_pcc} !== 10'b0) begin n_err++; $display("FAIL rmf_outs: got %b want 0", {o_lb, o_lpc, o_bub, o_kill, o_pcc}); end
      n_vec++; if ({st1, st0} !== 4'b0) begin n_err++; $display("FAIL rmf_state: got %b want 0000", {st1, st0}); end
      n_vec++; if ({f0, f1} !== 36'b0) begin n_err++; $display("FAIL rmf_cnt: got %h want 0", {f0, f1}); end
      @(posedge clk); #1; rst = 1; idle();
      settle();
      n_vec++; if (st1 !== 2'd0) begin n_err++; $display("FAIL rmf_first_state: got %0d want 0", st1); end
      n_vec++; if ({o_kill, o_lpc} !== 4'b0011) begin n_err++; $display("FAIL rmf_first_ctl: got %b want 0011", {o_kill, o_lpc}); end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         id_valid = $urandom_range(0, 3) != 0;
         id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
         id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
         ex_valid = $urandom_range(0, 3) != 0; ex_is_load = 1'($urandom_range(0, 1));
         ex_rd = 5'($urandom_range(0, 7)); ex_mispredict = $urandom_range(0, 9) == 0;
         mem_valid = 1'($urandom_range(0, 1)); mem_is_mem = 1'($urandom_range(0, 1));
         inst_mem_resp = $urandom_range(0, 4) != 0; data_mem_resp = $urandom_range(0, 3) != 0;
         settle();
         model_eval();
         n_vec++; if (o_lb !== {e_lb, e_lb}) begin n_err++; $display("FAIL rnd_lb@%0d: got %b want %b%b", i, o_lb, e_lb, e_lb); end
         n_vec++; if (o_pcc !== {redir, redir}) begin n_err++; $display("FAIL rnd_pcc@%0d: got %b want %b%b", i, o_pcc, redir, redir); end
         n_vec++; if (o_lpc !== e_lpc) begin n_err++; $display("FAIL rnd_lpc@%0d: got %b want %b", i, o_lpc, e_lpc); end
         n_vec++; if (o_bub !== e_bub) begin n_err++; $display("FAIL rnd_bub@%0d: got %b want %b", i, o_bub, e_bub); end
         n_vec++; if (o_kill !== e_kill) begin n_err++; $display("FAIL rnd_kill@%0d: got %b want %b", i, o_kill, e_kill); end
         n_vec++; if ({st1, st0} !== {2'(e_st[1]), 2'(e_st[0])}) begin n_err++; $display("FAIL rnd_state@%0d: got %0d/%0d want %0d/%0d", i, st1, st0, e_st[1], e_st[0]); end
         n_vec++; if ({s0, b0, f0} !== {32'(m_stall[0]), 32'(m_bub[0]), 32'(m_flush[0])}) begin n_err++; $display("FAIL rnd_cnt0@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, s0, b0, f0, m_stall[0], m_bub[0], m_flush[0]); end
         n_vec++; if ({s1, b1, f1} !== {4'(m_stall[1]), 4'(m_bub[1]), 4'(m_flush[1])}) begin n_err++; $display("FAIL rnd_cnt1@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, s1, b1, f1, m_stall[1], m_bub[1], m_flush[1]); end
         @(posedge clk);
         model_step();
         #1;
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_lat3();
      test_redirect_hazard();
      test_mem_stall();
      test_flush();
      test_saturate();
      test_reset_mid_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
